// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester round-robin arbiter sharing one cache/memory slave port.
// One transaction is latched at a time: IDLE (grant) -> ISSUE (strobe until s_ready) -> DONE
// (one-cycle ready pulse to the granted requester). All outputs come straight from flops.
// Optional macro ARB_TIMEOUT_EN adds an ISSUE watchdog that aborts after TIMEOUT_CYCLES cycles
// and flags the abort on mX_err; without it ISSUE waits indefinitely and mX_err stays 0.
module mem_bus_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_rd,
  input  logic                  m0_wr,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ready,
  output logic                  m0_err,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_rd,
  input  logic                  m1_wr,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ready,
  output logic                  m1_err,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic                  s_rd,
  output logic                  s_wr,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic                  s_ready,
  output logic                  grant_id,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e                state_q, state_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic                  grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  s_rd_q, s_rd_d;
  logic                  s_wr_q, s_wr_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic                  m0_ready_q, m0_ready_d;
  logic                  m1_ready_q, m1_ready_d;
  logic                  m0_err_q, m0_err_d;
  logic                  m1_err_q, m1_err_d;
  logic                  busy_q, busy_d;

  logic                  m0_req, m1_req;
  logic                  gnt;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] cap_data;

  assign m0_req = m0_rd | m0_wr;
  assign m1_req = m1_rd | m1_wr;

`ifdef ARB_TIMEOUT_EN
  localparam int CntRaw = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CntW   = (CntRaw < 8) ? 8 : ((CntRaw > 32) ? 32 : CntRaw);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count ISSUE cycles without s_ready; zero everywhere else so each ISSUE entry starts fresh.
  always_comb begin
    cnt_d = '0;
    if (state_q == StIssue && !s_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the last permitted ISSUE cycle so the strobe stays high TIMEOUT_CYCLES cycles.
  assign timeout = (state_q == StIssue) && (cnt_q >= CntLast);
`else
  assign timeout = 1'b0;
`endif

  // Next-state logic: arbitration, slave strobes, completion data and pulses.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    s_rd_d     = s_rd_q;
    s_wr_d     = s_wr_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    m0_err_d   = 1'b0;
    m1_err_d   = 1'b0;
    busy_d     = busy_q;
    gnt        = 1'b0;
    cap_data   = '0;

    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          gnt      = (m0_req && m1_req) ? rr_ptr_q : m1_req;
          grant_d  = gnt;
          rr_ptr_d = ~gnt;
          addr_d   = gnt ? m1_addr : m0_addr;
          wdata_d  = gnt ? m1_wdata : m0_wdata;
          // Write wins when a requester raises both strobes.
          s_wr_d   = gnt ? m1_wr : m0_wr;
          s_rd_d   = ~s_wr_d;
          busy_d   = 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (s_ready || timeout) begin
          s_rd_d   = 1'b0;
          s_wr_d   = 1'b0;
          state_d  = StDone;
          // s_ready wins over a simultaneous timeout; writes and aborts return zero.
          cap_data = (s_ready && !s_wr_q) ? s_rdata : '0;
          if (grant_q) begin
            m1_rdata_d = cap_data;
            m1_ready_d = 1'b1;
            m1_err_d   = timeout && !s_ready;
          end else begin
            m0_rdata_d = cap_data;
            m0_ready_d = 1'b1;
            m0_err_d   = timeout && !s_ready;
          end
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset drops the slave strobes immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= 1'b0;
      grant_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      s_rd_q     <= 1'b0;
      s_wr_q     <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      s_rd_q     <= s_rd_d;
      s_wr_q     <= s_wr_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
      busy_q     <= busy_d;
    end
  end

  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_rd     = s_rd_q;
  assign s_wr     = s_wr_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign m0_ready = m0_ready_q;
  assign m1_ready = m1_ready_q;
  assign m0_err   = m0_err_q;
  assign m1_err   = m1_err_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed requests feed per-port requester agents,
// expected slave issues and requester completions are queued, and independent monitors pop
// and compare them when the DUT strobes the slave or pulses a ready.
module tb_mem_bus_arbiter;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 8;

  logic          clk, reset;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic          m0_rd, m0_wr, m0_ready, m0_err;
  logic          m1_rd, m1_wr, m1_ready, m1_err;
  logic          s_rd, s_wr, s_ready, grant_id, busy;

  mem_bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rd(m0_rd), .m0_wr(m0_wr),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rd(m1_rd), .m1_wr(m1_wr),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rd(s_rd), .s_wr(s_wr),
    .s_rdata(s_rdata), .s_ready(s_ready), .grant_id(grant_id), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {logic rd; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata;} cmd_t;
  typedef struct {
    logic port; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; int wait_cyc; int len;
  } iss_t;
  typedef struct {logic port; logic [DW-1:0] rdata; logic err;} rsp_t;

  cmd_t cmdq0[$], cmdq1[$];
  iss_t issq[$];
  rsp_t rspq[$];
  int n_cmp = 0;
  int n_err = 0;
  int slv_k = 0;
  logic [DW-1:0] last_rdata [2];
  logic          last_port;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return (a == 16'h0010) ? 32'hDEAD_BEEF : {16'hA5A5, a};
  endfunction

  task automatic expect_txn(input bit p, input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input int wt, input int len,
                            input bit to, input bit has_rsp);
    iss_t i;
    rsp_t r;
    i.port = p; i.wr = wr; i.addr = a; i.wdata = wd; i.wait_cyc = wt; i.len = len;
    issq.push_back(i);
    if (has_rsp) begin
      r.port  = p;
      r.err   = to;
      r.rdata = (to || wr) ? '0 : slave_data(a);
      rspq.push_back(r);
      last_rdata[p] = r.rdata;
      last_port     = p;
    end
  endtask

  task automatic send(input bit p, input bit rd, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = a; c.wdata = wd;
    if (p) cmdq1.push_back(c);
    else cmdq0.push_back(c);
  endtask

  task automatic drive(input bit p, input cmd_t c);
    if (p) begin
      m1_rd = c.rd; m1_wr = c.wr; m1_addr = c.addr; m1_wdata = c.wdata;
    end else begin
      m0_rd = c.rd; m0_wr = c.wr; m0_addr = c.addr; m0_wdata = c.wdata;
    end
  endtask

  // Requester agent: holds a command until its ready is sampled, then moves on next edge.
  task automatic agent(input bit p);
    cmd_t c, idle;
    bit   done;
    int   n;
    idle.rd = 1'b0; idle.wr = 1'b0; idle.addr = '0; idle.wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || (p ? (cmdq1.size() == 0) : (cmdq0.size() == 0))) begin
        drive(p, idle);
        continue;
      end
      c = p ? cmdq1.pop_front() : cmdq0.pop_front();
      drive(p, c);
      done = 1'b0;
      n = 0;
      while (!done) begin
        @(negedge clk);
        n++;
        if (reset || (p ? m1_ready : m0_ready)) done = 1'b1;
        else if (n > 100) begin
          report_fail(p ? "m1_wait_ready" : "m0_wait_ready");
          done = 1'b1;
        end
      end
    end
  endtask

  initial agent(1'b0);
  initial agent(1'b1);

  // Slave model and issue monitor.
  initial begin
    iss_t cur;
    bit   active;
    active = 1'b0;
    cur.port = 0; cur.wr = 0; cur.addr = '0; cur.wdata = '0; cur.wait_cyc = 1; cur.len = 0;
    s_ready = 1'b0;
    s_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0; slv_k = 0; s_ready = 1'b0; s_rdata = '0;
      end else if (s_rd || s_wr) begin
        if (!active) begin
          active = 1'b1;
          slv_k  = 0;
          if (issq.size() == 0) begin
            report_fail("unexpected_issue");
          end else begin
            cur = issq.pop_front();
            check("issue_wr", s_wr, cur.wr);
            check("issue_rd", s_rd, !cur.wr);
            check("issue_grant", grant_id, cur.port);
            check("issue_busy", busy, 1);
          end
        end
        check("issue_addr", s_addr, cur.addr);
        check("issue_wdata", s_wdata, cur.wdata);
        slv_k++;
        s_ready = (cur.wait_cyc != 0) && (slv_k == cur.wait_cyc);
        s_rdata = s_ready ? slave_data(s_addr) : '0;
      end else begin
        if (active && cur.len != 0) check("strobe_len", slv_k, cur.len);
        active = 1'b0; slv_k = 0; s_ready = 1'b0; s_rdata = '0;
      end
    end
  end

  // Completion monitor.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("m0_err_without_ready", m0_err & ~m0_ready, 0);
        check("m1_err_without_ready", m1_err & ~m1_ready, 0);
        if (m0_ready || m1_ready) begin
          check("single_ready", m0_ready & m1_ready, 0);
          if (rspq.size() == 0) begin
            report_fail("unexpected_ready");
          end else begin
            e = rspq.pop_front();
            check("ready_port", m1_ready, e.port);
            check("rdata", e.port ? m1_rdata : m0_rdata, e.rdata);
            check("err", e.port ? m1_err : m0_err, e.err);
            check("done_grant_id", grant_id, e.port);
            check("done_busy", busy, 1);
            check("done_strobes_low", {s_rd, s_wr}, 0);
          end
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (issq.size() != 0 || rspq.size() != 0 || cmdq0.size() != 0 || cmdq1.size() != 0
           || busy) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        report_fail(name);
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    m0_rd = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
    m1_rd = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0;
    last_rdata[0] = '0;
    last_rdata[1] = '0;
    last_port = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s_strobes", {s_rd, s_wr}, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_wdata", s_wdata, 0);
    check("rst_busy_grant", {busy, grant_id}, 0);
    check("rst_ready_err", {m0_ready, m1_ready, m0_err, m1_err}, 0);
    check("rst_rdata", {m0_rdata, m1_rdata}, 0);
    reset = 1'b0;

    // Single read with explicit latency checks.
    expect_txn(0, 0, 16'h0010, 32'h0, 1, 1, 0, 1);
    send(0, 1, 0, 16'h0010, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("lat_c0_s_rd", s_rd, 0);
    @(negedge clk);
    check("lat_c1_s_rd", s_rd, 1);
    @(negedge clk);
    check("lat_c2_m0_ready", {m0_ready, m1_ready}, 2'b10);
    @(negedge clk);
    check("lat_c3_busy", busy, 0);
    wait_idle("single_read");

    // Write with four wait states on m1.
    expect_txn(1, 1, 16'h0ABC, 32'h1234_5678, 4, 4, 0, 1);
    send(1, 0, 1, 16'h0ABC, 32'h1234_5678);
    wait_idle("write_wait");

    // rd+wr together on m0 is a write.
    expect_txn(0, 1, 16'h0020, 32'hCAFE_F00D, 2, 2, 0, 1);
    send(0, 1, 1, 16'h0020, 32'hCAFE_F00D);
    wait_idle("rd_wr_both");

    // Contention: rr_ptr points at m1 after the m0 write.
    for (int i = 0; i < 4; i++) begin
      expect_txn(1, 0, 16'h0200 + 16'(i), 32'h0, 1, 1, 0, 1);
      expect_txn(0, 0, 16'h0100 + 16'(i), 32'h0, 1, 1, 0, 1);
    end
    for (int i = 0; i < 4; i++) begin
      send(0, 1, 0, 16'h0100 + 16'(i), 32'h0);
      send(1, 1, 0, 16'h0200 + 16'(i), 32'h0);
    end
    wait_idle("contention");

    // Reset in the middle of an ISSUE.
    expect_txn(1, 0, 16'h0440, 32'h0, 20, 0, 0, 0);
    send(1, 1, 0, 16'h0440, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (slv_k < 3 && n < 50);
    if (n >= 50) report_fail("reach_issue_for_reset");
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_strobes", {s_rd, s_wr}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", {m0_ready, m1_ready}, 0);
    check("mid_rst_grant", grant_id, 0);
    last_rdata[0] = '0;
    last_rdata[1] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_txn(0, 0, 16'h0300, 32'h0, 1, 1, 0, 1);
    expect_txn(1, 0, 16'h0400, 32'h0, 1, 1, 0, 1);
    send(0, 1, 0, 16'h0300, 32'h0);
    send(1, 1, 0, 16'h0400, 32'h0);
    wait_idle("post_reset_tie");

`ifdef ARB_TIMEOUT_EN
    // Slave never answers: abort after TO ISSUE cycles.
    expect_txn(0, 0, 16'h0500, 32'h0, 0, TO, 1, 1);
    send(0, 1, 0, 16'h0500, 32'h0);
    wait_idle("timeout_abort");
    // Slave answers on the last permitted cycle: s_ready wins.
    expect_txn(0, 0, 16'h0501, 32'h0, TO, TO, 0, 1);
    send(0, 1, 0, 16'h0501, 32'h0);
    wait_idle("timeout_tie");
`endif

    check("final_grant_hold", grant_id, last_port);
    check("final_m0_rdata_hold", m0_rdata, last_rdata[0]);
    check("final_m1_rdata_hold", m1_rdata, last_rdata[1]);
    check("final_idle", {busy, s_rd, s_wr}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
